// File: rtl/pll_lock_mgr.sv
// Reset and lock manager for the main PLL: timed PLL reset pulse, lock qualification, retry on timeout.
// Optional retry limit with FAIL state: define PLL_LOCK_MGR_RETRY_LIMIT_EN.
module pll_lock_mgr #(
   parameter int unsigned RST_CYCLES    = 24,
   parameter int unsigned LOCK_TIMEOUT  = 24000,
   parameter int unsigned STABLE_CYCLES = 240,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic       extlock,
   output logic       pll_reset,
   output logic       sys_reset,
   output logic       locked,
   output logic [3:0] retry_cnt,
   output logic       fail
);

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } state_t;

`ifdef PLL_LOCK_MGR_RETRY_LIMIT_EN
   localparam bit RETRY_LIMIT_EN = 1'b1;
`else
   localparam bit RETRY_LIMIT_EN = 1'b0;
`endif

   localparam logic [15:0] HOLD_LAST    = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
   localparam logic [4:0]  RETRY_LIMIT  = 5'(MAX_RETRY);

   state_t      state, next_state;
   logic [15:0] cnt;
   logic [3:0]  attempt_cnt;
   logic        sync_q1, lk;
   logic        timeout, retry_exhausted, counting;
   logic        pll_reset_d, sys_reset_d, locked_d, fail_d;

   // extlock is asynchronous; only the second flop's output is ever used.
   always_ff @(posedge refclk) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         lk      <= 1'b0;
      end else begin
         sync_q1 <= extlock;
         lk      <= sync_q1;
      end
   end

   assign timeout         = (state == ST_WAIT_LOCK) && !lk && (cnt == TIMEOUT_LAST);
   assign retry_exhausted = RETRY_LIMIT_EN && (({1'b0, attempt_cnt} + 5'd1) >= RETRY_LIMIT);
   assign counting        = (state == ST_HOLD) || (state == ST_WAIT_LOCK) || (state == ST_STABLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge refclk) begin
      if (reset) begin
         state       <= ST_HOLD;
         cnt         <= '0;
         attempt_cnt <= '0;
         retry_cnt   <= '0;
      end else begin
         state <= next_state;
         // The shared timer clears on every state change and never exceeds its limit, so it cannot wrap.
         if (next_state != state) cnt <= '0;
         else if (counting)       cnt <= cnt + 16'd1;
         if (timeout) begin
            if (retry_cnt != 4'hF)   retry_cnt   <= retry_cnt + 4'd1;
            if (attempt_cnt != 4'hF) attempt_cnt <= attempt_cnt + 4'd1;
         end else if (next_state == ST_RUN && state != ST_RUN) begin
            attempt_cnt <= '0;
         end
      end
   end

   // NOTE: next_state gets a default before the case so no latch is inferred.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_HOLD:      if (cnt == HOLD_LAST) next_state = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (lk)           next_state = ST_STABLE;
            else if (timeout) next_state = retry_exhausted ? ST_FAIL : ST_HOLD;
         end
         ST_STABLE: begin
            if (!lk)                     next_state = ST_WAIT_LOCK;
            else if (cnt == STABLE_LAST) next_state = ST_RUN;
         end
         ST_RUN:       if (!lk) next_state = ST_HOLD;
         ST_FAIL:      next_state = ST_FAIL;
         default:      next_state = ST_HOLD;
      endcase
   end

   // pll_reset follows the current state, so it lags sys_reset by one edge on lock loss.
   always_comb begin
      pll_reset_d = (state == ST_HOLD) || (state == ST_FAIL);
      sys_reset_d = (next_state != ST_RUN);
      locked_d    = (next_state == ST_RUN);
      fail_d      = RETRY_LIMIT_EN && (next_state == ST_FAIL);
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         pll_reset <= 1'b1;
         sys_reset <= 1'b1;
         locked    <= 1'b0;
         fail      <= 1'b0;
      end else begin
         pll_reset <= pll_reset_d;
         sys_reset <= sys_reset_d;
         locked    <= locked_d;
         fail      <= fail_d;
      end
   end

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Self-checking bench for pll_lock_mgr: directed scenarios plus randomized extlock against a phase-level model.
module tb_pll_lock_mgr;

   localparam int RST = 4;
   localparam int TO  = 20;
   localparam int STB = 4;
   localparam int MAXR = 2;
`ifdef PLL_LOCK_MGR_RETRY_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

   logic       refclk = 1'b0;
   logic       reset, extlock;
   logic       pll_reset, sys_reset, locked, fail;
   logic [3:0] retry_cnt;

   int errors = 0;
   int checks = 0;

   // Model state: spec phases with elapsed-cycle counts and a two-deep sample pipeline.
   int m_phase = P_HOLD, m_t = 0, m_retry = 0, m_attempts = 0;
   bit m_s1 = 0, m_s2 = 0;
   bit m_pll = 1, m_sys = 1, m_lock = 0, m_fail = 0;

   pll_lock_mgr #(
      .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB), .MAX_RETRY(MAXR)
   ) dut (
      .refclk(refclk), .reset(reset), .extlock(extlock), .pll_reset(pll_reset),
      .sys_reset(sys_reset), .locked(locked), .retry_cnt(retry_cnt), .fail(fail)
   );

   always #5 refclk = ~refclk;

   function automatic logic [7:0] dut_outs();
      return {pll_reset, sys_reset, locked, retry_cnt, fail};
   endfunction

   function automatic logic [7:0] model_outs();
      return {m_pll, m_sys, m_lock, 4'(m_retry), m_fail};
   endfunction

   task automatic model_edge(input bit rst, input bit ext);
      int old;
      bit lk;
      if (rst) begin
         m_phase = P_HOLD; m_t = 0; m_retry = 0; m_attempts = 0;
         m_s1 = 0; m_s2 = 0; m_pll = 1; m_sys = 1; m_lock = 0; m_fail = 0;
      end else begin
         lk  = m_s2;
         old = m_phase;
         case (m_phase)
            P_HOLD: begin
               m_t++;
               if (m_t == RST) begin m_phase = P_WAIT; m_t = 0; end
            end
            P_WAIT: begin
               if (lk) begin
                  m_phase = P_STABLE; m_t = 0;
               end else begin
                  m_t++;
                  if (m_t == TO) begin
                     if (m_retry < 15) m_retry++;
                     m_attempts++;
                     m_phase = (LIMIT && m_attempts >= MAXR) ? P_FAIL : P_HOLD;
                     m_t = 0;
                  end
               end
            end
            P_STABLE: begin
               if (!lk) begin
                  m_phase = P_WAIT; m_t = 0;
               end else begin
                  m_t++;
                  if (m_t == STB) begin m_phase = P_RUN; m_attempts = 0; end
               end
            end
            P_RUN: if (!lk) begin m_phase = P_HOLD; m_t = 0; end
            default: ;
         endcase
         m_pll  = (old == P_HOLD) || (old == P_FAIL);
         m_sys  = (m_phase != P_RUN);
         m_lock = (m_phase == P_RUN);
         m_fail = (m_phase == P_FAIL);
         m_s2 = m_s1;
         m_s1 = ext;
      end
   endtask

   // Drives one refclk edge; returns at the following falling edge with outputs settled.
   task automatic tick(input bit rst, input bit ext);
      reset   = rst;
      extlock = ext;
      @(posedge refclk);
      model_edge(rst, ext);
      @(negedge refclk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1, 0);
         checks++;
         if (dut_outs() !== 8'b1_1_0_0000_0) begin
            errors++;
            $display("FAIL reset_values cycle %0d: dut=%b want=%b", i, dut_outs(), 8'b1_1_0_0000_0);
         end
      end
   endtask

   task automatic test_power_up();
      for (int e = 1; e <= 16; e++) begin
         tick(0, e >= 10);
         if (e == 4 || e == 5) begin
            checks++;
            if (pll_reset !== (e == 4)) begin
               errors++;
               $display("FAIL power_up_pll_reset edge %0d: dut=%b want=%b", e, pll_reset, e == 4);
            end
         end
         if (e == 15 || e == 16) begin
            checks++;
            if ({sys_reset, locked, retry_cnt} !== {e == 15, e == 16, 4'd0}) begin
               errors++;
               $display("FAIL power_up_release edge %0d: dut=%b want=%b", e,
                        {sys_reset, locked, retry_cnt}, {e == 15, e == 16, 4'd0});
            end
         end
      end
   endtask

   task automatic test_lock_loss();
      logic [2:0] want;
      tick(0, 1);
      tick(0, 1);
      // Edge M samples extlock low; edges M+1..M+3 checked against the stated latencies.
      for (int k = 0; k <= 3; k++) begin
         tick(0, k >= 3);
         want = {k >= 3, k >= 2, k < 2};
         checks++;
         if ({pll_reset, sys_reset, locked} !== want) begin
            errors++;
            $display("FAIL lock_loss edge M+%0d: dut=%b want=%b", k, {pll_reset, sys_reset, locked}, want);
         end
      end
      for (int i = 0; i < 20; i++) tick(0, 1);
      checks++;
      if ({locked, sys_reset, retry_cnt} !== {1'b1, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL relock: dut=%b want=%b", {locked, sys_reset, retry_cnt}, {1'b1, 1'b0, 4'd0});
      end
   endtask

   task automatic test_bounce();
      tick(1, 0);
      tick(1, 0);
      for (int i = 0; i < 6; i++) tick(0, 0);
      // Edge a samples the first high; last rise sampled at a+3, release due at a+3+STB+2.
      for (int k = 0; k <= 9; k++) begin
         tick(0, k != 2);
         if (k == 8 || k == 9) begin
            checks++;
            if ({sys_reset, locked} !== {k == 8, k == 9}) begin
               errors++;
               $display("FAIL bounce_release edge a+%0d: dut=%b want=%b", k, {sys_reset, locked}, {k == 8, k == 9});
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic [6:0] want;
      int r;
      bit p, f;
      tick(1, 0);
      tick(1, 0);
      for (int e = 1; e <= 24 * 17; e++) begin
         tick(0, 0);
         r = (e / 24 > 15) ? 15 : e / 24;
         p = (e % 24 >= 1) && (e % 24 <= 4);
         f = 1'b0;
         if (LIMIT && e >= 48) begin
            r = 2;
            f = 1'b1;
            p = p || (e >= 49);
         end
         want = {p, 1'b1, 4'(r), f};
         checks++;
         if ({pll_reset, sys_reset, retry_cnt, fail} !== want) begin
            errors++;
            $display("FAIL timeout edge %0d: dut=%b want=%b", e, {pll_reset, sys_reset, retry_cnt, fail}, want);
         end
      end
   endtask

   task automatic test_reset_mid_stable();
      tick(1, 0);
      tick(1, 0);
      for (int i = 0; i < 6; i++) tick(0, 0);
      for (int k = 0; k <= 3; k++) tick(0, 1);
      checks++;
      if (model_outs() !== dut_outs()) begin
         errors++;
         $display("FAIL mid_stable_pre: dut=%b want=%b", dut_outs(), model_outs());
      end
      tick(1, 1);
      checks++;
      if (dut_outs() !== 8'b1_1_0_0000_0) begin
         errors++;
         $display("FAIL mid_stable_reset: dut=%b want=%b", dut_outs(), 8'b1_1_0_0000_0);
      end
   endtask

   task automatic test_random();
      int left = 0;
      bit val = 0;
      bit rst;
      tick(1, 0);
      for (int i = 0; i < 4000; i++) begin
         if (left == 0) begin
            val  = 1'($urandom_range(0, 1));
            left = $urandom_range(1, 40);
         end
         left--;
         rst = ($urandom_range(0, 299) == 0);
         tick(rst, val);
         checks++;
         if (dut_outs() !== model_outs()) begin
            errors++;
            $display("FAIL random cycle %0d: dut=%b model=%b", i, dut_outs(), model_outs());
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      extlock = 1'b0;
      @(negedge refclk);
      test_reset();
      test_power_up();
      test_lock_loss();
      test_bounce();
      test_timeout();
      test_reset_mid_stable();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
